// File: rtl/alu_slice_sequencer_pkg.sv
// Shared types and constants for the slice-serial ALU sequencer: FSM states,
// slice width and the ALU function-select/mode codes used by callers.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;

    localparam logic M_LOGIC = 1'b1;
    localparam logic M_ARITH = 1'b0;

endpackage

// File: rtl/alu_slice_sequencer.sv
// Runs a WIDTH-bit operation through an external combinational 4-bit ALU, one
// slice per clock, LSB first. Optional macro ALU_SEQ_BACK2BACK_EN accepts start in DONE.
module alu_slice_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_m,
    input  logic [3:0]       op_s,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             aeqb_all,
    output logic             alu_ncn,
    output logic             alu_m,
    output logic [3:0]       alu_s,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_f,
    input  logic             alu_aeqb,
    input  logic             alu_ncn4
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;
    logic [IDX_W-1:0] idx;
    logic             m_reg;
    logic [3:0]       s_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_n_reg;
    logic             aeq_acc;

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
`ifdef ALU_SEQ_BACK2BACK_EN
                // New operands latch while done still reports the previous op.
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            m_reg       <= 1'b0;
            s_reg       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            carry_n_reg <= 1'b1;
            aeq_acc     <= 1'b0;
            result      <= '0;
            cout_n      <= 1'b1;
            aeqb_all    <= 1'b0;
        end else if (accept) begin
            idx         <= '0;
            m_reg       <= op_m;
            s_reg       <= op_s;
            a_reg       <= op_a;
            b_reg       <= op_b;
            carry_n_reg <= cin_n;
            aeq_acc     <= 1'b1;
        end else if (state == RUN) begin
            for (int i = 0; i < NSLICE; i++) begin
                if (idx == IDX_W'(i)) begin
                    result[SLICE_W*i +: SLICE_W] <= alu_f;
                end
            end
            carry_n_reg <= alu_ncn4;
            aeq_acc     <= aeq_acc & alu_aeqb;
            idx         <= last ? '0 : idx + 1'b1;
            // Summary flags land on the final slice edge so they are valid with done.
            if (last) begin
                cout_n   <= (m_reg == M_LOGIC) ? 1'b1 : alu_ncn4;
                aeqb_all <= aeq_acc & alu_aeqb;
            end
        end
    end

    always_comb begin
        alu_ncn = 1'b1;
        alu_m   = 1'b0;
        alu_s   = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (state == RUN) begin
            alu_ncn = carry_n_reg;
            alu_m   = m_reg;
            alu_s   = s_reg;
            for (int i = 0; i < NSLICE; i++) begin
                if (idx == IDX_W'(i)) begin
                    alu_a = a_reg[SLICE_W*i +: SLICE_W];
                    alu_b = b_reg[SLICE_W*i +: SLICE_W];
                end
            end
        end
    end

endmodule
